// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and stall/flush/MUL control outputs
interface hazard_ctrl_if #(parameter int REG_W = 4, parameter int CNT_W = 16);
   logic             ID_EX_MemRead;
   logic [REG_W-1:0] ID_EX_RegisterRT;
   logic [REG_W-1:0] IF_ID_RegisterRS;
   logic [REG_W-1:0] IF_ID_RegisterRT;
   logic             IF_ID_UsesRT;
   logic             IF_ID_MulOp;
   logic             ID_Valid;
   logic             Branch_Taken;
   logic             PC_Write;
   logic             IF_ID_Write;
   logic             ID_EX_Bubble;
   logic             IF_ID_Flush;
   logic             ID_EX_Flush;
   logic             Mul_Start;
   logic             Mul_Busy;
   logic [1:0]       Ctrl_State;
   logic [CNT_W-1:0] Stall_Cnt;
   modport master (
      output ID_EX_MemRead, ID_EX_RegisterRT, IF_ID_RegisterRS, IF_ID_RegisterRT,
             IF_ID_UsesRT, IF_ID_MulOp, ID_Valid, Branch_Taken,
      input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
             Mul_Start, Mul_Busy, Ctrl_State, Stall_Cnt
   );
   modport slave (
      input  ID_EX_MemRead, ID_EX_RegisterRT, IF_ID_RegisterRS, IF_ID_RegisterRT,
             IF_ID_UsesRT, IF_ID_MulOp, ID_Valid, Branch_Taken,
      output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
             Mul_Start, Mul_Busy, Ctrl_State, Stall_Cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush, multi-cycle MUL sequencing and stall counter
module hazard_ctrl #(
   parameter int REG_W      = 4,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input logic clk,
   input logic rst,
   hazard_ctrl_if.slave h
);
   localparam int MC_W = $clog2(MUL_CYCLES);
   typedef enum logic [1:0] {RUN = 2'b00, MUL_WAIT = 2'b01, MUL_DONE = 2'b10} state_t;
   state_t           r_state;
   logic [MC_W-1:0]  r_cnt;
   logic [CNT_W-1:0] r_stall;
   logic [REG_W-1:0] w_rt;
   logic             w_lu, w_wait, w_eval, w_br, w_start, w_hold;
   assign w_rt    = h.ID_EX_RegisterRT;
   assign w_lu    = h.ID_EX_MemRead && (w_rt != '0) &&
                    (w_rt == h.IF_ID_RegisterRS || (h.IF_ID_UsesRT && w_rt == h.IF_ID_RegisterRT));
   assign w_wait  = !rst && r_state == MUL_WAIT;
   // RUN and MUL_DONE both honour branches and load-use; only RUN may start a MUL
   assign w_eval  = !rst && (r_state == RUN || r_state == MUL_DONE);
   assign w_br    = w_eval && h.Branch_Taken;
   assign w_start = w_eval && r_state == RUN && !h.Branch_Taken && !w_lu && h.IF_ID_MulOp && h.ID_Valid;
   assign w_hold  = (w_eval && !h.Branch_Taken && w_lu) || w_start || w_wait;
   assign h.PC_Write     = !w_hold;
   assign h.IF_ID_Write  = !w_hold;
   assign h.ID_EX_Bubble = w_hold;
   assign h.IF_ID_Flush  = w_br;
   assign h.ID_EX_Flush  = w_br;
   assign h.Mul_Start    = w_start;
   assign h.Mul_Busy     = w_wait;
   assign h.Ctrl_State   = r_state;
   assign h.Stall_Cnt    = r_stall;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
         r_stall <= '0;
      end else begin
         r_stall <= (w_hold && !(&r_stall)) ? r_stall + CNT_W'(1) : r_stall;
         r_cnt   <= w_start ? MC_W'(MUL_CYCLES - 1) : w_wait ? r_cnt - MC_W'(1) : r_cnt;
         r_state <= w_start ? MUL_WAIT : (w_wait && r_cnt == MC_W'(1)) ? MUL_DONE : w_wait ? MUL_WAIT : RUN;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MUL_CYCLES=4, CNT_W=4)
module tb_hazard_ctrl;
   typedef struct packed {
      logic       pc;
      logic       ifl;
      logic       exf;
      logic       ms;
      logic       mb;
      logic [1:0] st;
      logic [3:0] cnt;
   } exp_t;
   logic clk = 0;
   logic rst = 1;
   int   n_err = 0;
   int   n_chk = 0;
   exp_t q[$];
   hazard_ctrl_if #(.REG_W(4), .CNT_W(4)) h();
   hazard_ctrl #(.REG_W(4), .MUL_CYCLES(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .h(h));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask
   function automatic exp_t mk(logic pc, logic ifl, logic exf, logic ms, logic mb, logic [1:0] st, logic [3:0] cnt);
      return '{pc: pc, ifl: ifl, exf: exf, ms: ms, mb: mb, st: st, cnt: cnt};
   endfunction
   task automatic si(input logic mr, input logic [3:0] exrt, input logic [3:0] rs, input logic [3:0] rt,
                     input logic ur, input logic mo, input logic v, input logic br);
      h.ID_EX_MemRead    = mr;
      h.ID_EX_RegisterRT = exrt;
      h.IF_ID_RegisterRS = rs;
      h.IF_ID_RegisterRT = rt;
      h.IF_ID_UsesRT     = ur;
      h.IF_ID_MulOp      = mo;
      h.ID_Valid         = v;
      h.Branch_Taken     = br;
   endtask
   task automatic pop_cmp();
      exp_t e;
      if (q.size() == 0) begin
         chk("sb_empty", 1, 0);
         return;
      end
      e = q.pop_front();
      chk("pc_write", 32'(h.PC_Write), 32'(e.pc));
      chk("ifid_write", 32'(h.IF_ID_Write), 32'(e.pc));
      chk("bubble", 32'(h.ID_EX_Bubble), 32'(!e.pc));
      chk("ifid_flush", 32'(h.IF_ID_Flush), 32'(e.ifl));
      chk("idex_flush", 32'(h.ID_EX_Flush), 32'(e.exf));
      chk("mul_start", 32'(h.Mul_Start), 32'(e.ms));
      chk("mul_busy", 32'(h.Mul_Busy), 32'(e.mb));
      chk("state", 32'(h.Ctrl_State), 32'(e.st));
      chk("stall_cnt", 32'(h.Stall_Cnt), 32'(e.cnt));
   endtask
   task automatic cyc(input exp_t e);
      q.push_back(e);
      #2;
      pop_cmp();
      @(negedge clk);
   endtask
   initial begin
      si(1, 5, 5, 0, 0, 1, 1, 0);
      @(negedge clk);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 0));
      rst = 0;
      // load-use stall, then release
      cyc(mk(0, 0, 0, 0, 0, 2'b00, 0));
      si(0, 5, 5, 0, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 1));
      // no-stall cases: r0 and RT match without UsesRT; then RT match with UsesRT
      si(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 1));
      si(1, 7, 3, 7, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 1));
      si(1, 7, 3, 7, 1, 0, 0, 0);
      cyc(mk(0, 0, 0, 0, 0, 2'b00, 1));
      // MUL sequence; hazards during MUL_WAIT are ignored, MulOp ignored in MUL_DONE
      si(0, 0, 0, 0, 0, 1, 1, 0);
      cyc(mk(0, 0, 0, 1, 0, 2'b00, 2));
      cyc(mk(0, 0, 0, 0, 1, 2'b01, 3));
      si(1, 5, 5, 0, 0, 1, 1, 1);
      cyc(mk(0, 0, 0, 0, 1, 2'b01, 4));
      si(0, 0, 0, 0, 0, 1, 1, 0);
      cyc(mk(0, 0, 0, 0, 1, 2'b01, 5));
      cyc(mk(1, 0, 0, 0, 0, 2'b10, 6));
      si(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 6));
      // branch beats load-use beats MUL
      si(1, 5, 5, 0, 0, 1, 1, 1);
      cyc(mk(1, 1, 1, 0, 0, 2'b00, 6));
      si(1, 5, 5, 0, 0, 1, 1, 0);
      cyc(mk(0, 0, 0, 0, 0, 2'b00, 6));
      si(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 7));
      // async reset on 2nd MUL_WAIT cycle
      si(0, 0, 0, 0, 0, 1, 1, 0);
      cyc(mk(0, 0, 0, 1, 0, 2'b00, 7));
      cyc(mk(0, 0, 0, 0, 1, 2'b01, 8));
      q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 9));
      #2;
      pop_cmp();
      rst = 1;
      q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0));
      #1;
      pop_cmp();
      @(negedge clk);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 0));
      rst = 0;
      si(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 0));
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 0));
      // saturation at 15 over 20 load-use cycles
      si(1, 9, 9, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(mk(0, 0, 0, 0, 0, 2'b00, 4'((i > 15) ? 15 : i)));
      si(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 15));
      cyc(mk(1, 0, 0, 0, 0, 2'b00, 15));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
